// File: rtl/audio_gain_pump.sv
// -----------------------------------------------------------------------------
// audio_gain_pump
//
// Stereo sample pump for the audio loopback path. Pops one packed frame from
// the ADC-side FIFO, scales each channel by a signed Q2.14 gain with
// round-half-up and saturation, then pushes the result to the DAC-side FIFO.
// A full DAC FIFO stalls the pump; no new frame is popped while one is held.
//
// Optional feature macro: AUDIO_PUMP_SOFTMUTE_EN
//   defined   : mute ramps an extra Q2.14 attenuation stage (ATT state) down
//               or up by RAMP_STEP per pushed frame.
//   undefined : mute zeroes the latched gains (hard mute on the next frame).
//
// Ports
//   clk                system clock (shared with both FIFO ports)
//   reset              asynchronous, active-high reset
//   adcfifo_empty      ADC FIFO empty flag
//   adcfifo_read       one-cycle pop strobe
//   adcfifo_readdata   popped frame, valid the cycle after adcfifo_read
//   dacfifo_full       DAC FIFO full flag
//   dacfifo_write      one-cycle push strobe
//   dacfifo_writedata  processed frame, stable while waiting to push
//   gain_l, gain_r     signed Q2.14 channel gains (0x4000 = unity)
//   mute               mute request
//   sat_count          saturating count of clamped channel results
//   busy               high whenever a frame is in flight
// -----------------------------------------------------------------------------
module audio_gain_pump #(
   parameter int DATA_WIDTH = 32
`ifdef AUDIO_PUMP_SOFTMUTE_EN
   ,
   parameter int RAMP_STEP  = 64
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  adcfifo_empty,
   output logic                  adcfifo_read,
   input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
   input  logic                  dacfifo_full,
   output logic                  dacfifo_write,
   output logic [DATA_WIDTH-1:0] dacfifo_writedata,
   input  logic [15:0]           gain_l,
   input  logic [15:0]           gain_r,
   input  logic                  mute,
   output logic [15:0]           sat_count,
   output logic                  busy
);

   localparam int CW = DATA_WIDTH / 2;   // channel width
   localparam int PW = CW + 16;          // full product width

   localparam logic signed [PW-1:0] RND   = PW'(8192);
   localparam logic signed [PW-1:0] R_MAX = PW'((64'sd1 <<< (CW-1)) - 64'sd1);
   localparam logic signed [PW-1:0] R_MIN = ~R_MAX;
   localparam logic [15:0]          UNITY = 16'h4000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MUL,
      S_SAT,
`ifdef AUDIO_PUMP_SOFTMUTE_EN
      S_ATT,
`endif
      S_WRITE
   } state_t;

   // Q2.14 product -> rounded, clamped channel value; MSB flags a clamp.
   function automatic logic [CW:0] round_clamp(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + RND) >>> 14;
      if (r > R_MAX)
         round_clamp = {1'b1, R_MAX[CW-1:0]};
      else if (r < R_MIN)
         round_clamp = {1'b1, R_MIN[CW-1:0]};
      else
         round_clamp = {1'b0, r[CW-1:0]};
   endfunction

   function automatic logic [15:0] count_add(input logic [15:0] c, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, c} + 17'(inc[0]) + 17'(inc[1]);
      count_add = s[16] ? 16'hFFFF : s[15:0];
   endfunction

   state_t                 state_reg;
   logic signed [CW-1:0]   sample_reg [2];   // [0] = left, [1] = right
   logic signed [15:0]     gain_reg   [2];
   logic signed [PW-1:0]   prod_reg   [2];
   logic [DATA_WIDTH-1:0]  writedata_reg;
   logic [15:0]            sat_count_reg;
   logic [CW:0]            sat_res    [2];
   logic [1:0]             sat_inc;

`ifdef AUDIO_PUMP_SOFTMUTE_EN
   logic signed [CW-1:0]   scaled_reg [2];
   logic [15:0]            att_reg;
   logic signed [PW-1:0]   att_prod   [2];
   logic [CW:0]            att_res    [2];
   logic [1:0]             att_inc;
   logic [16:0]            att_up;

   assign att_up = {1'b0, att_reg} + 17'(RAMP_STEP);
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         assign sat_res[gi] = round_clamp(prod_reg[gi]);
         assign sat_inc[gi] = sat_res[gi][CW];
`ifdef AUDIO_PUMP_SOFTMUTE_EN
         assign att_prod[gi] = PW'(scaled_reg[gi]) * PW'($signed(att_reg));
         assign att_res[gi]  = round_clamp(att_prod[gi]);
         assign att_inc[gi]  = att_res[gi][CW];
`endif
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         writedata_reg <= '0;
         sat_count_reg <= '0;
         for (int i = 0; i < 2; i++) begin
            sample_reg[i] <= '0;
            gain_reg[i]   <= '0;
            prod_reg[i]   <= '0;
`ifdef AUDIO_PUMP_SOFTMUTE_EN
            scaled_reg[i] <= '0;
`endif
         end
`ifdef AUDIO_PUMP_SOFTMUTE_EN
         att_reg <= UNITY;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (!adcfifo_empty)
                  state_reg <= S_FETCH;
            end
            S_FETCH: begin
               sample_reg[0] <= $signed(adcfifo_readdata[DATA_WIDTH-1:CW]);
               sample_reg[1] <= $signed(adcfifo_readdata[CW-1:0]);
`ifdef AUDIO_PUMP_SOFTMUTE_EN
               gain_reg[0] <= $signed(gain_l);
               gain_reg[1] <= $signed(gain_r);
`else
               gain_reg[0] <= mute ? '0 : $signed(gain_l);
               gain_reg[1] <= mute ? '0 : $signed(gain_r);
`endif
               state_reg <= S_MUL;
            end
            S_MUL: begin
               for (int i = 0; i < 2; i++)
                  prod_reg[i] <= PW'(sample_reg[i]) * PW'(gain_reg[i]);
               state_reg <= S_SAT;
            end
            S_SAT: begin
               sat_count_reg <= count_add(sat_count_reg, sat_inc);
`ifdef AUDIO_PUMP_SOFTMUTE_EN
               for (int i = 0; i < 2; i++)
                  scaled_reg[i] <= sat_res[i][CW-1:0];
               state_reg <= S_ATT;
`else
               writedata_reg <= {sat_res[0][CW-1:0], sat_res[1][CW-1:0]};
               state_reg     <= S_WRITE;
`endif
            end
`ifdef AUDIO_PUMP_SOFTMUTE_EN
            S_ATT: begin
               sat_count_reg <= count_add(sat_count_reg, att_inc);
               writedata_reg <= {att_res[0][CW-1:0], att_res[1][CW-1:0]};
               state_reg     <= S_WRITE;
            end
`endif
            S_WRITE: begin
               if (!dacfifo_full) begin
                  state_reg <= S_IDLE;
`ifdef AUDIO_PUMP_SOFTMUTE_EN
                  // The frame just pushed was scaled with the old value.
                  if (mute)
                     att_reg <= (att_reg > 16'(RAMP_STEP)) ? att_reg - 16'(RAMP_STEP) : '0;
                  else
                     att_reg <= (att_up > 17'(UNITY)) ? UNITY : att_up[15:0];
`endif
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the state so a pop and the capture of its data
   // take two adjacent cycles, giving a 5-cycle frame period. The pop is also
   // gated by reset so nothing is requested while reset is held.
   assign adcfifo_read      = (state_reg == S_IDLE) && !adcfifo_empty && !reset;
   assign dacfifo_write     = (state_reg == S_WRITE) && !dacfifo_full;
   assign dacfifo_writedata = writedata_reg;
   assign sat_count         = sat_count_reg;
   assign busy              = (state_reg != S_IDLE);

endmodule

// File: tb/tb_audio_gain_pump.sv
// -----------------------------------------------------------------------------
// tb_audio_gain_pump
//
// Directed bench for audio_gain_pump in its default build: unity, rounding,
// saturation, back-pressure, hard mute, back-to-back frames and reset during
// a frame. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_audio_gain_pump;

   logic        clk = 1'b0;
   logic        reset;
   logic        adcfifo_empty;
   logic        adcfifo_read;
   logic [31:0] adcfifo_readdata;
   logic        dacfifo_full;
   logic        dacfifo_write;
   logic [31:0] dacfifo_writedata;
   logic [15:0] gain_l;
   logic [15:0] gain_r;
   logic        mute;
   logic [15:0] sat_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   audio_gain_pump #(.DATA_WIDTH(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .adcfifo_empty     (adcfifo_empty),
      .adcfifo_read      (adcfifo_read),
      .adcfifo_readdata  (adcfifo_readdata),
      .dacfifo_full      (dacfifo_full),
      .dacfifo_write     (dacfifo_write),
      .dacfifo_writedata (dacfifo_writedata),
      .gain_l            (gain_l),
      .gain_r            (gain_r),
      .mute              (mute),
      .sat_count         (sat_count),
      .busy              (busy)
   );

   // Offers one frame and follows it until its push (bounded at 30 cycles).
   task automatic push_frame(input logic [31:0] frame, output logic [31:0] got,
                             output int lat, output int reads);
      int rc;
      int writes;
      rc = -1; lat = -1; reads = 0; writes = 0; got = 32'hDEADBEEF;
      @(negedge clk);
      adcfifo_readdata = frame;
      adcfifo_empty    = 1'b0;
      #1;
      for (int cyc = 0; cyc < 30 && writes == 0; cyc++) begin
         if (adcfifo_read) begin
            reads++;
            if (rc < 0) rc = cyc;
         end
         if (dacfifo_write) begin
            writes++;
            got = dacfifo_writedata;
            lat = cyc - rc;
         end
         @(negedge clk);
         if (reads > 0) adcfifo_empty = 1'b1;
         #1;
      end
      $display("frame in=%h out=%h latency=%0d pops=%0d sat_count=%0d", frame, got, lat, reads, sat_count);
   endtask

   task automatic test_reset;
      reset = 1'b1; adcfifo_empty = 1'b0; dacfifo_full = 1'b0;
      adcfifo_readdata = 32'h0; gain_l = 16'h4000; gain_r = 16'h4000; mute = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (adcfifo_read !== 1'b0) begin errors++; $display("FAIL reset_read_held: got %b expected 0", adcfifo_read); end
      adcfifo_empty = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (adcfifo_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", adcfifo_read); end
      checks++; if (dacfifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", dacfifo_write); end
      checks++; if (dacfifo_writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata: got %h expected 00000000", dacfifo_writedata); end
      checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat_count: got %h expected 0000", sat_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_unity;
      logic [31:0] got; int lat; int reads;
      gain_l = 16'h4000; gain_r = 16'h4000; mute = 1'b0;
      push_frame(32'h1234EDCC, got, lat, reads);
      checks++; if (got !== 32'h1234EDCC) begin errors++; $display("FAIL unity_data: got %h expected 1234edcc", got); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL unity_latency: got %0d expected 4", lat); end
      checks++; if (reads !== 1) begin errors++; $display("FAIL unity_pops: got %0d expected 1", reads); end
      checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL unity_sat_count: got %0d expected 0", sat_count); end
   endtask

   task automatic test_rounding;
      logic [31:0] got; int lat; int reads;
      gain_l = 16'h2000; gain_r = 16'h2000;
      push_frame(32'h0003FFFD, got, lat, reads);
      checks++; if (got !== 32'h0002FFFF) begin errors++; $display("FAIL round_a: got %h expected 0002ffff", got); end
      push_frame(32'h0001FFFF, got, lat, reads);
      checks++; if (got !== 32'h00010000) begin errors++; $display("FAIL round_b: got %h expected 00010000", got); end
   endtask

   task automatic test_saturation;
      logic [31:0] got; int lat; int reads;
      gain_l = 16'h7FFF; gain_r = 16'h8000;
      push_frame(32'h7FFF8000, got, lat, reads);
      checks++; if (got !== 32'h7FFF7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff7fff", got); end
      checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_count_two: got %0d expected 2", sat_count); end
      gain_l = 16'h8000; gain_r = 16'h4000;
      push_frame(32'h7FFF0001, got, lat, reads);
      checks++; if (got !== 32'h80000001) begin errors++; $display("FAIL sat_neg: got %h expected 80000001", got); end
      checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL sat_count_one: got %0d expected 3", sat_count); end
   endtask

   task automatic test_back_pressure;
      int hold_reads; int hold_writes; int unstable; int done;
      gain_l = 16'h4000; gain_r = 16'h4000;
      @(negedge clk);
      dacfifo_full     = 1'b1;
      adcfifo_readdata = 32'hA5A55A5A;
      adcfifo_empty    = 1'b0;
      #1;
      checks++; if (adcfifo_read !== 1'b1) begin errors++; $display("FAIL bp_first_pop: got %b expected 1", adcfifo_read); end
      repeat (4) begin @(negedge clk); #1; end
      hold_reads = 0; hold_writes = 0; unstable = 0;
      for (int i = 0; i < 20; i++) begin
         if (adcfifo_read) hold_reads++;
         if (dacfifo_write) hold_writes++;
         if (dacfifo_writedata !== 32'hA5A55A5A) unstable++;
         @(negedge clk); #1;
      end
      checks++; if (hold_writes !== 0) begin errors++; $display("FAIL bp_no_push: got %0d pushes expected 0", hold_writes); end
      checks++; if (hold_reads !== 0) begin errors++; $display("FAIL bp_no_pop: got %0d pops expected 0", hold_reads); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changed cycles expected 0", unstable); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
      dacfifo_full     = 1'b0;
      adcfifo_readdata = 32'h00010002;
      #1;
      checks++; if (dacfifo_write !== 1'b1) begin errors++; $display("FAIL bp_release_push: got %b expected 1", dacfifo_write); end
      checks++; if (dacfifo_writedata !== 32'hA5A55A5A) begin errors++; $display("FAIL bp_release_data: got %h expected a5a55a5a", dacfifo_writedata); end
      checks++; if (adcfifo_read !== 1'b0) begin errors++; $display("FAIL bp_release_nopop: got %b expected 0", adcfifo_read); end
      $display("frame in=a5a55a5a out=%h pushed after 20 held cycles", dacfifo_writedata);
      @(negedge clk); #1;
      checks++; if (adcfifo_read !== 1'b1) begin errors++; $display("FAIL bp_next_pop: got %b expected 1", adcfifo_read); end
      checks++; if (dacfifo_write !== 1'b0) begin errors++; $display("FAIL bp_single_push: got %b expected 0", dacfifo_write); end
      @(negedge clk);
      adcfifo_empty = 1'b1;
      #1;
      done = 0;
      for (int i = 0; i < 10 && done == 0; i++) begin
         if (dacfifo_write) begin
            done = 1;
            checks++; if (dacfifo_writedata !== 32'h00010002) begin errors++; $display("FAIL bp_next_data: got %h expected 00010002", dacfifo_writedata); end
            $display("frame in=00010002 out=%h", dacfifo_writedata);
         end
         @(negedge clk); #1;
      end
      checks++; if (done !== 1) begin errors++; $display("FAIL bp_next_timeout: got %0d pushes expected 1", done); end
   endtask

   task automatic test_mute;
      logic [31:0] got; int lat; int reads;
      gain_l = 16'h4000; gain_r = 16'h4000; mute = 1'b1;
      push_frame(32'h40004000, got, lat, reads);
      checks++; if (got !== 32'h00000000) begin errors++; $display("FAIL mute_on: got %h expected 00000000", got); end
      mute = 1'b0;
      push_frame(32'h40004000, got, lat, reads);
      checks++; if (got !== 32'h40004000) begin errors++; $display("FAIL mute_off: got %h expected 40004000", got); end
   endtask

   task automatic test_back_to_back;
      int rcyc [8]; int nreads; int nwrites; int baddata; int done;
      gain_l = 16'h4000; gain_r = 16'h4000;
      nreads = 0; nwrites = 0; baddata = 0;
      @(negedge clk);
      adcfifo_readdata = 32'h11112222;
      adcfifo_empty    = 1'b0;
      #1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (adcfifo_read) begin
            if (nreads < 8) rcyc[nreads] = cyc;
            nreads++;
         end
         if (dacfifo_write) begin
            nwrites++;
            if (dacfifo_writedata !== 32'h11112222) baddata++;
         end
         @(negedge clk); #1;
      end
      adcfifo_empty = 1'b1;
      checks++; if (nreads !== 4) begin errors++; $display("FAIL b2b_pops: got %0d expected 4", nreads); end
      checks++; if (nwrites !== 3) begin errors++; $display("FAIL b2b_pushes: got %0d expected 3", nwrites); end
      checks++; if (baddata !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad pushes expected 0", baddata); end
      if (nreads >= 3) begin
         checks++; if (rcyc[1] - rcyc[0] !== 5) begin errors++; $display("FAIL b2b_period_a: got %0d expected 5", rcyc[1] - rcyc[0]); end
         checks++; if (rcyc[2] - rcyc[1] !== 5) begin errors++; $display("FAIL b2b_period_b: got %0d expected 5", rcyc[2] - rcyc[1]); end
      end
      $display("back-to-back pops=%0d pushes=%0d", nreads, nwrites);
      done = 0;
      for (int i = 0; i < 10 && done == 0; i++) begin
         if (dacfifo_write) done = 1;
         @(negedge clk); #1;
      end
      checks++; if (done !== 1) begin errors++; $display("FAIL b2b_drain: got %0d pushes expected 1", done); end
   endtask

   task automatic test_reset_mid;
      int stray;
      gain_l = 16'h4000; gain_r = 16'h4000;
      @(negedge clk);
      adcfifo_readdata = 32'h01000100;
      adcfifo_empty    = 1'b0;
      @(negedge clk);                   // FETCH
      adcfifo_empty = 1'b1;
      @(negedge clk);                   // MUL
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
      adcfifo_empty = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      checks++; if (dacfifo_writedata !== 32'h0) begin errors++; $display("FAIL rst_mid_writedata: got %h expected 00000000", dacfifo_writedata); end
      checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL rst_mid_sat_count: got %h expected 0000", sat_count); end
      checks++; if (adcfifo_read !== 1'b0) begin errors++; $display("FAIL rst_mid_read: got %b expected 0", adcfifo_read); end
      checks++; if (dacfifo_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got %b expected 0", dacfifo_write); end
      adcfifo_empty = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (dacfifo_write) stray++;
         @(negedge clk); #1;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_dropped: got %0d pushes expected 0", stray); end
      $display("reset during MUL: frame dropped, pushes after reset=%0d", stray);
   endtask

   initial begin
      test_reset();
      test_unity();
      test_rounding();
      test_saturation();
      test_back_pressure();
      test_mute();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_gain_pump.md
# audio_gain_pump

Single-clock stereo sample pump between the ADC-side FIFO (I2S receive) and the DAC-side FIFO (I2S transmit) of the audio loopback path. It pops one packed stereo frame, applies a per-channel signed Q2.14 gain with round-half-up and saturation, and pushes the result. Back-pressure from the DAC FIFO propagates to the ADC FIFO. Saturation events are counted for debug and LED use.

## Interface

- DATA_WIDTH, 32, packed frame width; left channel = [DATA_WIDTH-1:DATA_WIDTH/2], right channel = [DATA_WIDTH/2-1:0]; each channel is signed two's complement.
- RAMP_STEP, 64, soft-mute attenuation step per frame (only with the macro).

- clk  in  1  system clock; same clock as both FIFO ports.
- reset  in  1  asynchronous, active-high reset.
- adcfifo_empty  in  1  ADC FIFO empty flag.
- adcfifo_read  out  1  one-cycle pop strobe.
- adcfifo_readdata  in  DATA_WIDTH  frame, valid the cycle after adcfifo_read.
- dacfifo_full  in  1  DAC FIFO full flag.
- dacfifo_write  out  1  one-cycle push strobe.
- dacfifo_writedata  out  DATA_WIDTH  processed frame.
- gain_l, gain_r  in  16  signed Q2.14 gain; 0x4000 is unity, 0x8000 is -2.0.
- mute  in  1  mute request.
- sat_count  out  16  count of saturated channel results.
- busy  out  1  high whenever state is not IDLE.

## Operation

- FSM states: IDLE, FETCH, MUL, SAT, (ATT, macro only), WRITE.
- IDLE: if !adcfifo_empty, assert adcfifo_read for one cycle and go to FETCH. Otherwise stay.
- FETCH: capture adcfifo_readdata into the L/R sample registers and latch gain_l/gain_r (mute forces the latched gains to 0 without the macro), then go to MUL. Gain changes affect only frames not yet fetched.
- MUL: 16x16 signed product per channel into 32-bit registers, then go to SAT.
- SAT: add 0x2000, arithmetic shift right by 14, clamp to [-32768, 32767]. Add 1 to sat_count per clamped channel (0, 1 or 2 per frame); sat_count holds at 0xFFFF. Then go to WRITE (or ATT).
- WRITE: dacfifo_writedata is registered and stable throughout. When !dacfifo_full, pulse dacfifo_write for one cycle and go to IDLE. While full, hold with no pops.
- No pop is issued while any frame is in flight, so at most one frame is held.

## Timing

- Reset values: adcfifo_read=0, dacfifo_write=0, dacfifo_writedata=0, sat_count=0, busy=0, state=IDLE; soft-mute attenuation=0x4000.
- Reset mid-operation clears everything immediately; a frame already popped but not pushed is dropped.
- Latency, no back-pressure: the write pulse comes 4 cycles after the read pulse (5 with the macro).
- Minimum frame period is 5 cycles (6 with the macro).
- Simultaneous empty deassertion and full in WRITE: the push waits; the pop happens only after returning to IDLE.
- dacfifo_full asserting the same cycle the FSM enters WRITE: no push.

## Configuration

- AUDIO_PUMP_SOFTMUTE_EN defined:
  - mute does not zero the gains.
  - An extra ATT state multiplies each saturated result by a Q2.14 attenuation register, with the same rounding, clamping and sat_count rules.
  - The attenuation is updated on each push: when mute=1, decrease by RAMP_STEP (floor 0); when mute=0, increase by RAMP_STEP (cap 0x4000).
  - Each push uses the attenuation value from before that push's update.
- Undefined: no ATT state; mute zeroes the gains at FETCH, giving a hard mute on the next fetched frame.

## Test plan

- Unity: gains 0x4000, frame 0x1234EDCC -> push 0x1234EDCC exactly 4 cycles after the pop; sat_count=0.
- Rounding: gains 0x2000, frame 0x0003FFFD -> 0x0002FFFF.
- Saturation: gain_l=0x7FFF, gain_r=0x8000, frame 0x7FFF8000 -> 0x7FFF7FFF; sat_count increments by 2.
- Back-pressure: dacfifo_full held 20 cycles while in WRITE -> no push, dacfifo_writedata stable, no pops; on release, exactly one push, then the next pop.
- Mute:
  - Without the macro: mute=1, frame 0x40004000 -> 0x00000000.
  - With the macro: pushes are 0x40004000, 0x3FC03FC0, 0x3F803F80, ... reaching 0 on push 257. Deasserting mute ramps back up by 64 per frame.
- Async reset asserted during MUL -> outputs 0 within the same cycle, state IDLE, sat_count=0; no push for the dropped frame.
